dmem_port_arbiter: RTL and testbench

- Shares the single data-memory bus between the IF-stage requester (I-side, read-only) and the MEM-stage load/store requester (D-side).
- Sequences each bus transaction through a valid/ready request phase and a response phase, with one transaction outstanding at a time.
- Steers each registered response back to the requester that owns it.
- D-side has fixed priority, bounded by an anti-starvation limit for the I-side.

---
 rtl/dmem_port_arbiter_if.sv | 24 ++
 rtl/dmem_port_arbiter.sv | 90 +++++++++
 tb/tb_dmem_port_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: I-side, D-side and memory-bus signals of the data-memory port arbiter.
// The slave modport is the arbiter's view; master is the requesters/bus view.
interface dmem_port_arbiter_if;
  logic        i_i_valid, o_i_ready, o_i_rvalid, o_i_error;
  logic [31:0] i_i_addr, o_i_rdata;
  logic        i_d_valid, o_d_ready, i_d_wr_en, o_d_rvalid, o_d_error;
  logic [31:0] i_d_addr, i_d_wdata, o_d_rdata;
  logic [3:0]  i_d_sel;
  logic        o_m_valid, i_m_ready, o_m_wr_en, i_m_rvalid, i_m_error;
  logic [31:0] o_m_addr, o_m_wdata, i_m_rdata;
  logic [3:0]  o_m_sel;
  modport slave (
    input  i_i_valid, i_i_addr, i_d_valid, i_d_addr, i_d_wr_en, i_d_sel, i_d_wdata,
           i_m_ready, i_m_rvalid, i_m_rdata, i_m_error,
    output o_i_ready, o_i_rvalid, o_i_rdata, o_i_error, o_d_ready, o_d_rvalid, o_d_rdata, o_d_error,
           o_m_valid, o_m_addr, o_m_wr_en, o_m_sel, o_m_wdata
  );
  modport master (
    output i_i_valid, i_i_addr, i_d_valid, i_d_addr, i_d_wr_en, i_d_sel, i_d_wdata,
           i_m_ready, i_m_rvalid, i_m_rdata, i_m_error,
    input  o_i_ready, o_i_rvalid, o_i_rdata, o_i_error, o_d_ready, o_d_rvalid, o_d_rdata, o_d_error,
           o_m_valid, o_m_addr, o_m_wr_en, o_m_sel, o_m_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory bus between I-fetch and D load/store, one transaction in flight.
// Define ARB_TIMEOUT_EN to abort ISSUE/WAIT after TIMEOUT_CYCLES with an error response.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst_n,
  dmem_port_arbiter_if.slave p
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t      state_q, state_d;
  logic        own_d_q;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q, wdata_q, i_rdata_q, d_rdata_q, rsp_data;
  logic [3:0]  sel_q;
  logic        wr_q, i_rvalid_q, i_error_q, d_rvalid_q, d_error_q;
  logic        grant_d, grant_i, resp, abort, done, rsp_err;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else tmo_q <= grant_d || grant_i ? 8'd0 : state_q != IDLE ? tmo_q + 8'd1 : tmo_q;
  assign abort = state_q != IDLE && tmo_q == 8'(TIMEOUT_CYCLES - 1);
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    grant_d  = state_q == IDLE && p.i_d_valid && !(p.i_i_valid && starve_q == 4'(STARVE_LIMIT));
    grant_i  = state_q == IDLE && p.i_i_valid && !grant_d;
    resp     = state_q == WAIT && p.i_m_rvalid;
    done     = resp || abort;
    rsp_data = resp && !wr_q ? p.i_m_rdata : '0;
    rsp_err  = resp ? p.i_m_error : 1'b1;
    state_d  = done ? IDLE : grant_d || grant_i ? ISSUE : state_q == ISSUE && p.i_m_ready ? WAIT : state_q;
    starve_d = grant_i || (grant_d && !p.i_i_valid) ? 4'd0 : grant_d ? starve_q + 4'd1 : starve_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      own_d_q    <= 1'b0;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      wr_q       <= 1'b0;
      i_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      i_error_q  <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      i_rvalid_q <= done && !own_d_q;
      d_rvalid_q <= done && own_d_q;
      if (grant_d || grant_i) begin
        own_d_q <= grant_d;
        addr_q  <= grant_d ? p.i_d_addr : p.i_i_addr;
        wr_q    <= grant_d && p.i_d_wr_en;
        sel_q   <= grant_d ? p.i_d_sel : 4'hF;
        wdata_q <= grant_d ? p.i_d_wdata : '0;
      end
      if (done && !own_d_q) begin
        i_rdata_q <= rsp_data;
        i_error_q <= rsp_err;
      end
      if (done && own_d_q) begin
        d_rdata_q <= rsp_data;
        d_error_q <= rsp_err;
      end
    end
  assign p.o_d_ready  = grant_d;
  assign p.o_i_ready  = grant_i;
  assign p.o_m_valid  = state_q == ISSUE;
  assign p.o_m_addr   = state_q == ISSUE ? addr_q : '0;
  assign p.o_m_wr_en  = state_q == ISSUE && wr_q;
  assign p.o_m_sel    = state_q == ISSUE ? sel_q : '0;
  assign p.o_m_wdata  = state_q == ISSUE ? wdata_q : '0;
  assign p.o_i_rvalid = i_rvalid_q;
  assign p.o_i_rdata  = i_rdata_q;
  assign p.o_i_error  = i_error_q;
  assign p.o_d_rvalid = d_rvalid_q;
  assign p.o_d_rdata  = d_rdata_q;
  assign p.o_d_error  = d_error_q;
  // Bus responses outside WAIT are protocol violations and are dropped by the FSM.
  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst_n) p.i_m_rvalid |-> state_q == WAIT);
  a_params: assert property (@(posedge clk) STARVE_LIMIT inside {[1:15]} && TIMEOUT_CYCLES inside {[1:255]});
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for dmem_port_arbiter with a simple memory-bus responder.
module tb_dmem_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  dmem_port_arbiter_if p();
  dmem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .p(p));
  int total = 0, bad = 0, stall = 0;
  logic mute = 1'b0;
  logic [32:0] dq[$], iq[$];
  string order = "";

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input logic wr);
    return {a[31:28] == 4'hE, wr ? 32'h0 : ~a};
  endfunction

  task automatic d_req(input logic [31:0] a, input logic wr, input logic [3:0] sel, input logic [31:0] wd, output int lat);
    p.i_d_valid = 1'b1; p.i_d_addr = a; p.i_d_wr_en = wr; p.i_d_sel = sel; p.i_d_wdata = wd;
    lat = 0;
    @(negedge clk);
    while (!p.o_d_ready && lat < 100) begin lat++; @(negedge clk); end
    chk("d_grant", p.o_d_ready, 1);
    dq.push_back(mute ? 33'h1_0000_0000 : model(a, wr));
    order = {order, "D"};
    @(posedge clk); #1;
    p.i_d_valid = 1'b0;
  endtask

  task automatic i_req(input logic [31:0] a, output int lat);
    p.i_i_valid = 1'b1; p.i_i_addr = a;
    lat = 0;
    @(negedge clk);
    while (!p.o_i_ready && lat < 100) begin lat++; @(negedge clk); end
    chk("i_grant", p.o_i_ready, 1);
    iq.push_back(model(a, 1'b0));
    order = {order, "I"};
    @(posedge clk); #1;
    p.i_i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((dq.size() + iq.size()) != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", dq.size() + iq.size(), 0);
    @(posedge clk); #1;
  endtask

  // Bus responder: accepts when ready, answers one cycle after acceptance.
  initial begin
    logic acc, w;
    logic [31:0] a;
    p.i_m_ready = 1'b1; p.i_m_rvalid = 1'b0; p.i_m_rdata = '0; p.i_m_error = 1'b0;
    forever begin
      @(negedge clk);
      acc = p.o_m_valid && p.i_m_ready && !mute;
      a = p.o_m_addr;
      w = p.o_m_wr_en;
      if (p.o_m_valid && !p.i_m_ready && stall > 0) stall--;
      @(posedge clk); #1;
      p.i_m_rvalid = acc;
      p.i_m_rdata  = acc ? (w ? 32'h5555_5555 : ~a) : 32'h0BAD_0BAD;
      p.i_m_error  = acc ? a[31:28] == 4'hE : 1'b1;
      p.i_m_ready  = stall == 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && p.o_d_rvalid) begin
      if (dq.size() == 0) chk("d_spurious", 1, 0);
      else chk("d_rsp", {p.o_d_error, p.o_d_rdata}, dq.pop_front());
    end
    if (rst_n && p.o_i_rvalid) begin
      if (iq.size() == 0) chk("i_spurious", 1, 0);
      else chk("i_rsp", {p.o_i_error, p.o_i_rdata}, iq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ld, li, n;
    p.i_i_valid = 1'b0; p.i_i_addr = '0;
    p.i_d_valid = 1'b0; p.i_d_addr = '0; p.i_d_wr_en = 1'b0; p.i_d_sel = '0; p.i_d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_m", {p.o_m_valid, p.o_m_wr_en, p.o_m_sel, p.o_m_addr}, 0);
    chk("rst_m_wdata", p.o_m_wdata, 0);
    chk("rst_ctl", {p.o_i_rvalid, p.o_i_error, p.o_d_rvalid, p.o_d_error, p.o_i_ready, p.o_d_ready}, 0);
    chk("rst_rdata", {p.o_i_rdata, p.o_d_rdata}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    d_req(32'h100, 1'b0, 4'hF, 32'h0, lat);
    chk("ld_lat", lat, 0);
    @(negedge clk); chk("ld_issue", {p.o_m_valid, p.o_m_wr_en, p.o_m_addr}, {2'b10, 32'h100});
    @(negedge clk); chk("ld_wait", p.o_m_valid, 0);
    @(negedge clk); chk("ld_rvalid", {p.o_d_rvalid, p.o_i_rvalid}, 2'b10);
    wait_idle();
    d_req(32'h204, 1'b1, 4'b0011, 32'h0000_ABCD, lat);
    @(negedge clk); chk("st_issue", {p.o_m_wr_en, p.o_m_sel, p.o_m_wdata, p.o_m_addr}, {1'b1, 4'h3, 32'h0000_ABCD, 32'h204});
    wait_idle();
    stall = 5;
    @(posedge clk); #1;
    fork
      begin
        d_req(32'h300, 1'b0, 4'hF, 32'h0, ld);
        d_req(32'h304, 1'b0, 4'hF, 32'h0, ld);
      end
      begin
        int c, g;
        c = 0; g = 0;
        @(negedge clk);
        while (!p.o_m_valid && g < 10) begin g++; @(negedge clk); end
        while (p.o_m_valid && c < 20) begin
          c++;
          if (p.o_m_addr !== 32'h300 || p.o_d_ready || p.o_i_ready)
            chk("bp_stable", {p.o_m_addr, p.o_d_ready, p.o_i_ready}, {32'h300, 2'b00});
          @(negedge clk);
        end
        chk("bp_len", c, 6);
        chk("bp_hold", p.o_d_ready, 0);
      end
    join
    chk("bp_lat", ld, 7);
    wait_idle();
    i_req(32'hE000_0010, lat);
    @(negedge clk); chk("if_issue", {p.o_m_wr_en, p.o_m_sel, p.o_m_addr}, {1'b0, 4'hF, 32'hE000_0010});
    @(posedge clk); #1;
    i_req(32'h40, lat);
    wait_idle();
    order = "";
    fork
      for (int k = 0; k < 8; k++) d_req(32'h1000 + k * 4, !k[0], 4'hF, k, ld);
      for (int k = 0; k < 2; k++) i_req(32'h2000 + k * 4, li);
    join
    wait_idle();
    chk("order", order == "DDDDIDDDDI", 1);
    mute = 1'b1;
    d_req(32'h500, 1'b0, 4'hF, 32'h0, lat);
    n = 0;
    while (!p.o_d_rvalid && n < 20) begin @(negedge clk); n++; end
`ifdef ARB_TIMEOUT_EN
    chk("tmo_lat", n, 9);
    mute = 1'b0;
    wait_idle();
`else
    chk("no_tmo", dq.size(), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("rst_mid", {p.o_m_valid, p.o_d_rvalid, p.o_d_error, p.o_d_rdata}, 0);
    dq.delete();
    mute = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
`endif
    d_req(32'h600, 1'b0, 4'hF, 32'h0, lat);
    chk("recover_lat", lat, 0);
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
